// File: rtl/core_pkg.sv
// Shared encodings for the core's memory-port arbitration logic.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/wait_timer.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle whose increment would reach TIMEOUT.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the FSM leaves BUSY on the very edge the count reaches TIMEOUT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// data load/store, with a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    state_t state;
    grant_t grant;
    grant_t last_grant;
    logic   busy;
    logic   d_any;
    logic   expired;

    assign busy  = (state == BUSY_IF) || (state == BUSY_D);
    assign d_any = d_rd_req || d_wr_req;

    assign stall_if  = if_req && !if_ready;
    assign stall_mem = d_any && !d_ready;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (busy && !m_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_IF;
            last_grant <= GNT_IF;
            m_valid    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; non-blocking keeps every
            // branch below reading the pre-edge register values.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    // A fetch pending behind a just-served data access goes first.
                    if (if_req && (!d_any || last_grant == GNT_D)) begin
                        state   <= BUSY_IF;
                        grant   <= GNT_IF;
                        m_valid <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                    end else if (d_any) begin
                        state   <= BUSY_D;
                        grant   <= GNT_D;
                        m_valid <= 1'b1;
                        m_we    <= d_wr_req;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end
                end

                BUSY_IF, BUSY_D: begin
                    if (m_ack || expired) begin
                        state   <= DONE;
                        m_valid <= 1'b0;
                        m_we    <= 1'b0;
                        bus_err <= !m_ack;
                        if (grant == GNT_IF) begin
                            if_ready <= 1'b1;
                            if_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            d_ready <= 1'b1;
                            if (!m_ack) begin
                                d_rdata <= '0;
                            end else if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end
                end

                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after the falling
// edge, outputs are compared 1 ns later, so each step is one clock cycle.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_rd_req = 1'b0;
    logic              d_wr_req = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              m_ack = 1'b0;
    logic              stall_if;
    logic              stall_mem;
    logic              bus_err;

    int tests_run = 0;
    int tests_failed = 0;

    // {m_valid, m_we, if_ready, d_ready, bus_err}
    logic [4:0] flags;
    assign flags = {m_valid, m_we, if_ready, d_ready, bus_err};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .m_valid   (m_valid),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .bus_err   (bus_err)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic test_reset;
        #2;
        tests_run++;
        if ({flags, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: flags=%b m_addr=%h m_wdata=%h if_rdata=%h d_rdata=%h, required all zero",
                     flags, m_addr, m_wdata, if_rdata, d_rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if ({flags, stall_if, stall_mem} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: flags=%b stalls=%b%b, required zero", flags, stall_if, stall_mem);
        end
    endtask

    task automatic test_fetch;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
        tests_run++;
        if ({stall_if, flags} !== 6'b1_00000) begin
            tests_failed++;
            $display("FAIL fetch_t0: stall_if,flags=%b, required 100000", {stall_if, flags});
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) begin m_ack = 1'b1; m_rdata = 32'h8C22_0004; end
            #1;
            tests_run++;
            if ({stall_if, flags, m_addr} !== {6'b1_10000, 32'h40}) begin
                tests_failed++;
                $display("FAIL fetch_busy_t%0d: stall_if,flags=%b m_addr=%h, required 110000 00000040",
                         k, {stall_if, flags}, m_addr);
            end
        end
        @(negedge clk); m_ack = 1'b0; m_rdata = '0; #1;
        tests_run++;
        if ({stall_if, flags, if_rdata} !== {6'b0_00100, 32'h8C22_0004}) begin
            tests_failed++;
            $display("FAIL fetch_ready_t4: stall_if,flags=%b if_rdata=%h, required 000100 8c220004",
                     {stall_if, flags}, if_rdata);
        end
        @(negedge clk); if_req = 1'b0; #1;
        tests_run++;
        if (flags !== 5'b00000) begin
            tests_failed++;
            $display("FAIL fetch_after: flags=%b, required 00000", flags);
        end
    endtask

    task automatic test_arbitration;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h44;
        d_rd_req = 1'b1; d_addr = 32'h200;
        #1;
        tests_run++;
        if ({stall_if, stall_mem, flags} !== 7'b11_00000) begin
            tests_failed++;
            $display("FAIL arb_t0: stalls,flags=%b, required 1100000", {stall_if, stall_mem, flags});
        end
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'h1111_2222; #1;
        tests_run++;
        if ({flags, m_addr} !== {5'b10000, 32'h200}) begin
            tests_failed++;
            $display("FAIL arb_data_first: flags=%b m_addr=%h, required 10000 00000200", flags, m_addr);
        end
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({stall_if, stall_mem, flags, d_rdata} !== {7'b10_00010, 32'h1111_2222}) begin
            tests_failed++;
            $display("FAIL arb_data_ready: stalls,flags=%b d_rdata=%h, required 1000010 11112222",
                     {stall_if, stall_mem, flags}, d_rdata);
        end
        // New load arrives while the fetch still waits; last grant was data.
        @(negedge clk); d_addr = 32'h204; #1;
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'h3333_4444; #1;
        tests_run++;
        if ({flags, m_addr} !== {5'b10000, 32'h44}) begin
            tests_failed++;
            $display("FAIL arb_fetch_not_starved: flags=%b m_addr=%h, required 10000 00000044", flags, m_addr);
        end
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({flags, if_rdata} !== {5'b00100, 32'h3333_4444}) begin
            tests_failed++;
            $display("FAIL arb_fetch_ready: flags=%b if_rdata=%h, required 00100 33334444", flags, if_rdata);
        end
        @(negedge clk); if_req = 1'b0; #1;
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'h5555_6666; #1;
        tests_run++;
        if ({flags, m_addr} !== {5'b10000, 32'h204}) begin
            tests_failed++;
            $display("FAIL arb_second_load: flags=%b m_addr=%h, required 10000 00000204", flags, m_addr);
        end
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({flags, d_rdata} !== {5'b00010, 32'h5555_6666}) begin
            tests_failed++;
            $display("FAIL arb_second_ready: flags=%b d_rdata=%h, required 00010 55556666", flags, d_rdata);
        end
        @(negedge clk); d_rd_req = 1'b0; #1;
    endtask

    task automatic test_store(input logic also_rd, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        d_wr_req = 1'b1; d_rd_req = also_rd; d_addr = addr; d_wdata = wdata;
        #1;
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
        tests_run++;
        if ({flags, m_addr, m_wdata} !== {5'b11000, addr, wdata}) begin
            tests_failed++;
            $display("FAIL store_issue(rd=%b): flags=%b m_addr=%h m_wdata=%h, required 11000 %h %h",
                     also_rd, flags, m_addr, m_wdata, addr, wdata);
        end
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({flags, d_rdata} !== {5'b00010, 32'h5555_6666}) begin
            tests_failed++;
            $display("FAIL store_ready(rd=%b): flags=%b d_rdata=%h, required 00010 55556666",
                     also_rd, flags, d_rdata);
        end
        @(negedge clk); d_wr_req = 1'b0; d_rd_req = 1'b0; #1;
    endtask

    task automatic test_timeout;
        @(negedge clk); d_rd_req = 1'b1; d_addr = 32'h500; #1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk); #1;
            tests_run++;
            if (flags !== 5'b10000) begin
                tests_failed++;
                $display("FAIL timeout_busy_t%0d: flags=%b, required 10000", k, flags);
            end
        end
        @(negedge clk); #1;
        tests_run++;
        if ({flags, d_rdata} !== {5'b00011, 32'h0}) begin
            tests_failed++;
            $display("FAIL timeout_abort: flags=%b d_rdata=%h, required 00011 00000000", flags, d_rdata);
        end
        @(negedge clk); d_rd_req = 1'b0; m_ack = 1'b1; #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) m_ack = 1'b0;
            #1;
            tests_run++;
            if (flags !== 5'b00000) begin
                tests_failed++;
                $display("FAIL timeout_stray_ack_%0d: flags=%b, required 00000", k, flags);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); d_rd_req = 1'b1; d_addr = 32'h400; #1;
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'h0BAD_F00D; #1;
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({flags, d_rdata, stall_mem} !== {5'b00010, 32'h0BAD_F00D, 1'b0}) begin
            tests_failed++;
            $display("FAIL hold_ready: flags=%b d_rdata=%h stall_mem=%b, required 00010 0badf00d 0",
                     flags, d_rdata, stall_mem);
        end
        @(negedge clk); d_rd_req = 1'b0; #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            tests_run++;
            if (flags !== 5'b00000) begin
                tests_failed++;
                $display("FAIL hold_no_reissue_%0d: flags=%b, required 00000", k, flags);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk); d_rd_req = 1'b1; d_addr = 32'h300; #1;
        @(negedge clk); #1;
        tests_run++;
        if ({flags, m_addr} !== {5'b10000, 32'h300}) begin
            tests_failed++;
            $display("FAIL rst_busy: flags=%b m_addr=%h, required 10000 00000300", flags, m_addr);
        end
        #2; rst = 1'b1; #1;
        tests_run++;
        if ({flags, m_addr, d_rdata, stall_mem} !== {5'b00000, 32'h0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_async: flags=%b m_addr=%h d_rdata=%h stall_mem=%b, required 00000 0 0 1",
                     flags, m_addr, d_rdata, stall_mem);
        end
        d_rd_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h80; #1;
        @(negedge clk); m_ack = 1'b1; m_rdata = 32'hA5A5_A5A5; #1;
        tests_run++;
        if ({flags, m_addr} !== {5'b10000, 32'h80}) begin
            tests_failed++;
            $display("FAIL rst_refetch_issue: flags=%b m_addr=%h, required 10000 00000080", flags, m_addr);
        end
        @(negedge clk); m_ack = 1'b0; #1;
        tests_run++;
        if ({flags, if_rdata} !== {5'b00100, 32'hA5A5_A5A5}) begin
            tests_failed++;
            $display("FAIL rst_refetch_ready: flags=%b if_rdata=%h, required 00100 a5a5a5a5", flags, if_rdata);
        end
        @(negedge clk); if_req = 1'b0; #1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store(1'b0, 32'h100, 32'hDEAD_BEEF);
        test_store(1'b1, 32'h104, 32'h1234_5678);
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
